// File: rtl/grad_dac_arbiter_if.sv
// Channel request and serialiser bus shared by grad_dac_arbiter and its neighbours.
// The arbiter connects through the master modport; requesters and the serialiser
// model sit on the slave side.
interface grad_dac_arbiter_if #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int AW  = 2
) ();
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_valid_i;
  logic [NCH-1:0]    ch_ready_o;
  logic              frame_mode_i;
  logic [AW+DW-1:0]  ser_data_o;
  logic              ser_start_o;
  logic              ser_busy_i;
  logic              ldac_o;
  logic              err_o;
  logic              err_clr_i;
  logic              idle_o;

  modport master (
    input  ch_data_i, ch_valid_i, frame_mode_i, ser_busy_i, err_clr_i,
    output ch_ready_o, ser_data_o, ser_start_o, ldac_o, err_o, idle_o
  );

  modport slave (
    output ch_data_i, ch_valid_i, frame_mode_i, ser_busy_i, err_clr_i,
    input  ch_ready_o, ser_data_o, ser_start_o, ldac_o, err_o, idle_o
  );
endinterface

// File: rtl/grad_dac_arbiter.sv
// Gradient DAC arbiter: round-robin grant of NCH channel words onto one serialiser,
// start/busy handshake with start timeout, and LDAC strobe per word or per frame.
module grad_dac_arbiter #(
  parameter int NCH           = 4,
  parameter int DW            = 16,
  parameter int AW            = 2,
  parameter int LDAC_CYCLES   = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  grad_dac_arbiter_if.master bus
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int LW = $clog2(LDAC_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    LDAC
  } state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [NCH-1:0]   frame_mask;
  logic [TW-1:0]    to_cnt;
  logic [LW-1:0]    ld_cnt;
  logic [NCH-1:0]   ch_ready;
  logic [AW+DW-1:0] ser_data;
  logic             ser_start;
  logic             ldac;
  logic             err;

  logic [AW-1:0]    sel;
  logic [NCH-1:0]   sel_onehot;
  logic [DW-1:0]    sel_word;

  // First requesting channel after 'last', wrapping modulo NCH; 'last' itself
  // is tried last so the most recent winner has the lowest priority.
  function automatic logic [AW-1:0] rr_pick(input logic [NCH-1:0] req,
                                            input logic [AW-1:0]  last);
    logic [AW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(last) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        pick  = AW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Winner selection for the grant issued on leaving IDLE.
  always_comb begin
    sel        = rr_pick(bus.ch_valid_i, ptr);
    sel_onehot = {{(NCH-1){1'b0}}, 1'b1} << sel;
    sel_word   = bus.ch_data_i[int'(sel)*DW +: DW];
  end

  // Arbiter FSM. The grant is registered on the IDLE exit edge so that ready and
  // the captured word are visible throughout the GRANT cycle. to_cnt counts
  // cycles from the start strobe, so the timeout lands START_TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= AW'(NCH - 1);
      frame_mask <= '0;
      to_cnt     <= '0;
      ld_cnt     <= '0;
      ch_ready   <= '0;
      ser_data   <= '0;
      ser_start  <= 1'b0;
      ldac       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ch_ready  <= '0;
      ser_start <= 1'b0;
      // A timeout in the same cycle overrides this clear further down.
      if (bus.err_clr_i) err <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.ch_valid_i) begin
            state      <= GRANT;
            ch_ready   <= sel_onehot;
            ser_data   <= {sel, sel_word};
            ptr        <= sel;
            frame_mask <= frame_mask | sel_onehot;
          end else if ((|frame_mask) && bus.frame_mode_i) begin
            state  <= LDAC;
            ldac   <= 1'b1;
            ld_cnt <= '0;
          end
        end

        GRANT: begin
          state     <= LAUNCH;
          ser_start <= 1'b1;
          to_cnt    <= '0;
        end

        LAUNCH: begin
          state  <= WAIT_BUSY;
          to_cnt <= to_cnt + 1'b1;
        end

        WAIT_BUSY: begin
          if (bus.ser_busy_i) begin
            state <= WAIT_DONE;
          end else if (to_cnt >= TW'(START_TIMEOUT - 1)) begin
            // Word is lost: flag it and abandon the frame without loading the DAC.
            err        <= 1'b1;
            frame_mask <= '0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!bus.ser_busy_i) begin
            if (bus.frame_mode_i) begin
              state <= IDLE;
            end else begin
              state  <= LDAC;
              ldac   <= 1'b1;
              ld_cnt <= '0;
            end
          end
        end

        LDAC: begin
          if (ld_cnt == LW'(LDAC_CYCLES - 1)) begin
            ldac       <= 1'b0;
            frame_mask <= '0;
            state      <= IDLE;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ch_ready_o  = ch_ready;
  assign bus.ser_data_o  = ser_data;
  assign bus.ser_start_o = ser_start;
  assign bus.ldac_o      = ldac;
  assign bus.err_o       = err;
  assign bus.idle_o      = (state == IDLE) && !(|bus.ch_valid_i);

endmodule

// File: tb/tb_grad_dac_arbiter.sv
// Directed bench for grad_dac_arbiter with a launch scoreboard and a
// behavioural serialiser that raises busy for busy_len cycles per start.
module tb_grad_dac_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grad_dac_arbiter_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

  grad_dac_arbiter #(
    .NCH(NCH), .DW(DW), .AW(AW), .LDAC_CYCLES(4), .START_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] exp_q[$];
  int   ldac_pulses = 0;
  int   ldac_cycles = 0;
  logic ldac_prev   = 1'b0;
  int   busy_len    = 10;
  bit   stuck       = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    bus.ch_data_i[i*DW +: DW] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start();
    int t = 0;
    while (bus.ser_start_o !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", bus.ser_start_o, 1);
  endtask

  // Counts ready pulses; either drops each granted channel or drops all at the n-th grant.
  task automatic wait_grants(input int n, input bit drop_all);
    int got = 0;
    int t   = 0;
    while (got < n && t < 400) begin
      @(negedge clk);
      t++;
      if (bus.ch_ready_o != '0) begin
        got++;
        if (!drop_all) bus.ch_valid_i = bus.ch_valid_i & ~bus.ch_ready_o;
        if (drop_all && got == n) bus.ch_valid_i = '0;
      end
    end
    check("grant_count", got, n);
  endtask

  // Serialiser model
  initial begin
    bus.ser_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!stuck && rst_n && bus.ser_start_o) begin
        for (int i = 0; i < busy_len; i++) begin
          bus.ser_busy_i = 1'b1;
          @(negedge clk);
        end
        bus.ser_busy_i = 1'b0;
      end
    end
  end

  // Scoreboard and LDAC monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ser_start_o) begin
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL start_unexpected: observed launch of 0x%0h expected no launch", bus.ser_data_o);
          end
          if (exp_q.size() != 0) check("ser_data", bus.ser_data_o, exp_q.pop_front());
        end
        if (bus.ch_ready_o != '0) begin
          tests++;
          assert ($onehot(bus.ch_ready_o)) else begin
            fails++;
            $error("FAIL ready_onehot: observed 0x%0h expected one-hot", bus.ch_ready_o);
          end
        end
      end
      if (bus.ldac_o) ldac_cycles++;
      if (bus.ldac_o && !ldac_prev) ldac_pulses++;
      ldac_prev = bus.ldac_o;
    end
  end

  initial begin
    int p0;
    int c0;
    bus.ch_data_i    = '0;
    bus.ch_valid_i   = '0;
    bus.frame_mode_i = 1'b0;
    bus.err_clr_i    = 1'b0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ready", bus.ch_ready_o, 0);
    check("rst_ser_data", bus.ser_data_o, 0);
    check("rst_start", bus.ser_start_o, 0);
    check("rst_ldac", bus.ldac_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_idle", bus.idle_o, 1);
    rst_n = 1'b1;

    // Single word, per-word LDAC
    set_word(0, 16'h1234);
    bus.ch_valid_i = 4'b0001;
    exp_q.push_back({2'd0, 16'h1234});
    @(negedge clk);
    check("t1_ready_at_1", bus.ch_ready_o, 4'b0001);
    check("t1_no_start_at_1", bus.ser_start_o, 0);
    check("t1_idle_low", bus.idle_o, 0);
    @(negedge clk);
    check("t1_start_at_2", bus.ser_start_o, 1);
    check("t1_ser_data", bus.ser_data_o, 18'h01234);
    bus.ch_valid_i = '0;
    c0 = ldac_cycles;
    repeat (11) @(negedge clk);
    check("t1_ldac_after_busy", bus.ldac_o, 1);
    repeat (7) @(negedge clk);
    check("t1_ldac_cycles", ldac_cycles - c0, 4);
    check("t1_idle_after", bus.idle_o, 1);
    check("t1_ser_data_held", bus.ser_data_o, 18'h01234);

    // All channels continuously valid, per-word LDAC
    do_reset();
    busy_len = 3;
    for (int i = 0; i < NCH; i++) set_word(i, 16'hB000 + 16'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % NCH), 16'hB000 + 16'(i % NCH)});
    p0 = ldac_pulses;
    bus.ch_valid_i = 4'b1111;
    wait_grants(5, 1'b1);
    repeat (30) @(negedge clk);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_ldac_pulses", ldac_pulses - p0, 5);

    // One round in frame mode: single LDAC at the end of the frame
    do_reset();
    bus.frame_mode_i = 1'b1;
    for (int i = 0; i < NCH; i++) set_word(i, 16'hA000 + 16'(i));
    for (int i = 0; i < NCH; i++) exp_q.push_back({2'(i), 16'hA000 + 16'(i)});
    p0 = ldac_pulses;
    c0 = ldac_cycles;
    bus.ch_valid_i = 4'b1111;
    wait_grants(4, 1'b0);
    check("t3_no_ldac_between", ldac_pulses - p0, 0);
    repeat (30) @(negedge clk);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_ldac_pulses", ldac_pulses - p0, 1);
    check("t3_ldac_cycles", ldac_cycles - c0, 4);
    check("t3_idle", bus.idle_o, 1);

    // Serialiser never responds: timeout, no LDAC even in frame mode
    stuck = 1'b1;
    set_word(1, 16'hC001);
    exp_q.push_back({2'd1, 16'hC001});
    p0 = ldac_pulses;
    bus.ch_valid_i = 4'b0010;
    wait_start();
    bus.ch_valid_i = '0;
    repeat (7) @(negedge clk);
    check("t4_err_not_yet", bus.err_o, 0);
    @(negedge clk);
    check("t4_err_set", bus.err_o, 1);
    check("t4_idle", bus.idle_o, 1);
    repeat (10) @(negedge clk);
    check("t4_err_sticky", bus.err_o, 1);
    check("t4_no_ldac", ldac_pulses - p0, 0);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    check("t4_err_cleared", bus.err_o, 0);

    // Reset during WAIT_DONE, then pointer restarts at channel 0
    stuck = 1'b0;
    busy_len = 10;
    bus.frame_mode_i = 1'b0;
    set_word(2, 16'hD002);
    exp_q.push_back({2'd2, 16'hD002});
    bus.ch_valid_i = 4'b0100;
    wait_start();
    bus.ch_valid_i = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ser_data", bus.ser_data_o, 0);
    check("t5_rst_start", bus.ser_start_o, 0);
    check("t5_rst_ready", bus.ch_ready_o, 0);
    check("t5_rst_ldac", bus.ldac_o, 0);
    check("t5_rst_err", bus.err_o, 0);
    check("t5_rst_idle", bus.idle_o, 1);
    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    set_word(0, 16'hE000);
    set_word(3, 16'hE003);
    exp_q.push_back({2'd0, 16'hE000});
    exp_q.push_back({2'd3, 16'hE003});
    bus.ch_valid_i = 4'b1001;
    wait_grants(2, 1'b0);
    repeat (40) @(negedge clk);
    check("t5_queue_empty", exp_q.size(), 0);

    // Channel 2 held with channel 0: grants must alternate
    busy_len = 2;
    set_word(0, 16'hF000);
    set_word(2, 16'hF002);
    for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? {2'd0, 16'hF000} : {2'd2, 16'hF002});
    bus.ch_valid_i = 4'b0101;
    wait_grants(4, 1'b1);
    repeat (30) @(negedge clk);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_idle", bus.idle_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
